fsm_sar_scan: RTL and testbench
===============================

Name: fsm_sar_scan

Overview:
Parametrised multi-channel SAR ADC conversion controller, successor to the single-channel SAR FSM. Scans a programmable set of analog channels through an external mux, runs a binary-search conversion per channel with configurable sample and per-bit settle time, and delivers results with channel tags over a valid/ready handshake. It sits between the analog front end (mux, S/H, DAC, comparator) and the digital consumer (register file / FIFO).

Parameters:
Width, 10, conversion resolution in bits (>=2)
Channels, 4, number of mux inputs (>=1)
SampleCycles, 2, cycles sample_o is held high per channel (>=1)
SettleCycles, 1, cycles per bit trial; cmp_i sampled on the last one (>=1)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  synchronous active-low reset
start_i  in  1  start scan (accepted only in IDLE)
stop_i  in  1  finish the current channel, then return to IDLE
cont_i  in  1  continuous mode: rescan after last enabled channel
ch_mask_i  in  Channels  channel enable mask, latched at scan start/restart
cmp_i  in  1  comparator: 1 = Vin >= DAC
dac_o  out  Width  DAC trial code = res_reg | mask_reg
sample_o  out  1  S/H sample strobe
ch_sel_o  out  clog2(Channels) (min 1)  mux select of the active channel
busy_o  out  1  state != IDLE
scan_done_o  out  1  one-cycle pulse when a scan pass completes
result_o  out  Width  converted code
result_ch_o  out  clog2(Channels) (min 1)  channel of result_o
valid_o  out  1  result_o/result_ch_o valid
ready_i  in  1  consumer accepts the result

Behaviour:
- Reset (rst_ni low at an edge): state IDLE; mask_reg, res_reg, result_o, result_ch_o, ch_sel_o, scan mask and counters = 0; valid_o, scan_done_o, sample_o = 0. Reset overrides any operation mid-conversion; a pending result is discarded.
- States: IDLE, SAMPLE, CONVERT, STORE.
- IDLE: when start_i=1 and ch_mask_i != 0: latch the mask, ch_sel_o = lowest set bit, go to SAMPLE. start_i with an all-zero mask is ignored. start_i outside IDLE is ignored.
- SAMPLE: sample_o=1 for exactly SampleCycles cycles. On exit, mask_reg = 1<<(Width-1), res_reg = 0, go to CONVERT.
- CONVERT: each bit lasts SettleCycles cycles with dac_o stable. On the last cycle: if cmp_i then res_reg |= mask_reg; mask_reg >>= 1; if mask_reg[0] was 1, go to STORE. cmp_i is ignored in the other settle cycles.
- STORE: if valid_o=0 or ready_i=1, load result_o=res_reg and result_ch_o=ch_sel_o, set valid_o=1, and advance. Otherwise stall in STORE with no data loss, and hold dac_o/ch_sel_o.
- Advance:
  - If stop_i has been seen since the scan started (sticky, cleared in IDLE): go to IDLE.
  - Else if a higher enabled channel remains: select it, go to SAMPLE.
  - Else (pass complete): pulse scan_done_o. If cont_i=1, relatch ch_mask_i; if it is nonzero, select its lowest channel and go to SAMPLE, otherwise go to IDLE. If cont_i=0, go to IDLE.
- valid_o clears on valid_o && ready_i unless a new result loads in the same cycle; in that case valid_o stays 1 with the new data.
- ch_sel_o is constant from SAMPLE entry through STORE of a channel.
- Latency from start_i accepted to valid_o high: 1 + SampleCycles + Width*SettleCycles + 1 cycles, with no backpressure.
- dac_o in IDLE/SAMPLE = res_reg|mask_reg (0 after reset).

Decomposition:
- Package fsm_sar_pkg: state enum encoding (IDLE=0, SAMPLE=1, CONVERT=2, STORE=3) and a clog2-with-min-1 constant function.
- Sub-module sar_chan_pick: combinational "next enabled channel above index k / lowest set bit" priority encoder over Channels bits.

Test Plan:
1. Width=8, mask=0001, cmp_i modelled as (dac_o <= 8'hA5), ready_i=1 -> result_o=8'hA5, result_ch_o=0, valid_o at cycle 1+2+8+1=12 after start, scan_done_o pulse, busy_o falls.
2. mask=1010, Vin ch1=8'h3C, ch3=8'hFF -> results in order (ch1,3C) then (ch3,FF); ch0/ch2 never selected on ch_sel_o.
3. ready_i=0 for 20 cycles after the first result, two-channel scan -> FSM stalls in STORE, first result held unchanged, second delivered only after ready_i; no loss or duplicate.
4. cont_i=1, mask=0011 -> ch0, ch1, scan_done_o, ch0 repeats. Set mask=0 mid-scan -> IDLE after the pass; stop_i mid-CONVERT of ch0 -> ch0 result delivered, then IDLE, ch1 not sampled.
5. rst_ni low during CONVERT -> next cycle all outputs at reset values, valid_o=0. start_i with mask=0 -> stays IDLE.
6. SettleCycles=3, SampleCycles=1, Width=10 -> dac_o stable 3 cycles per bit, cmp_i toggled on non-final settle cycles ignored, result_o=10'h2AA for Vin=10'h2AA.

Source files
------------

// File: rtl/fsm_sar_scan_pkg.sv
// Shared types for the multi-channel SAR scan controller: FSM state encoding
// and a clog2 helper that never returns less than one bit.
package fsm_sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_STORE   = 2'd3
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fsm_sar_scan_chan_pick.sv
// Priority encoder over the channel mask: lowest set bit, optionally restricted
// to indices strictly above floor_i.
module sar_chan_pick #(
    parameter int Channels = 4,
    parameter int ChW      = 2
) (
    input  logic [Channels-1:0] mask_i,
    input  logic                above_en_i,
    input  logic [ChW-1:0]      floor_i,
    output logic                found_o,
    output logic [ChW-1:0]      idx_o
);

    // Scan downward so the last hit written is the lowest qualifying index.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = Channels - 1; i >= 0; i--) begin
            if (mask_i[i] && (!above_en_i || (i > int'(floor_i)))) begin
                found_o = 1'b1;
                idx_o   = ChW'(i);
            end
        end
    end

endmodule

// File: rtl/fsm_sar_scan.sv
// Multi-channel SAR conversion controller: walks the enabled channels through
// sample / binary-search / store and hands out tagged results over valid/ready.
module fsm_sar_scan
    import fsm_sar_pkg::*;
#(
    parameter  int Width        = 10,
    parameter  int Channels     = 4,
    parameter  int SampleCycles = 2,
    parameter  int SettleCycles = 1,
    localparam int ChW          = clog2_min1(Channels)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                cont_i,
    input  logic [Channels-1:0] ch_mask_i,
    input  logic                cmp_i,
    output logic [Width-1:0]    dac_o,
    output logic                sample_o,
    output logic [ChW-1:0]      ch_sel_o,
    output logic                busy_o,
    output logic                scan_done_o,
    output logic [Width-1:0]    result_o,
    output logic [ChW-1:0]      result_ch_o,
    output logic                valid_o,
    input  logic                ready_i
);

    localparam int CntMax = (SampleCycles > SettleCycles) ? SampleCycles : SettleCycles;
    localparam int CntW   = clog2_min1(CntMax);
    localparam logic [CntW-1:0] SampleLast = CntW'(SampleCycles - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);

    state_e              state_q, state_d;
    logic [Width-1:0]    mask_q, mask_d, res_q, res_d, result_q, result_d;
    logic [ChW-1:0]      ch_sel_q, ch_sel_d, result_ch_q, result_ch_d;
    logic [Channels-1:0] scan_mask_q, scan_mask_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                valid_q, valid_d, done_q, done_d, stop_q, stop_d;
    logic                nxt_found, new_found;
    logic [ChW-1:0]      nxt_idx, new_idx;

    // Next enabled channel above the active one, within the latched scan mask.
    sar_chan_pick #(.Channels(Channels), .ChW(ChW)) u_pick_next (
        .mask_i     (scan_mask_q),
        .above_en_i (1'b1),
        .floor_i    (ch_sel_q),
        .found_o    (nxt_found),
        .idx_o      (nxt_idx)
    );

    // First channel of a freshly latched mask (scan start or continuous restart).
    sar_chan_pick #(.Channels(Channels), .ChW(ChW)) u_pick_new (
        .mask_i     (ch_mask_i),
        .above_en_i (1'b0),
        .floor_i    ({ChW{1'b0}}),
        .found_o    (new_found),
        .idx_o      (new_idx)
    );

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        res_d       = res_q;
        result_d    = result_q;
        ch_sel_d    = ch_sel_q;
        result_ch_d = result_ch_q;
        scan_mask_d = scan_mask_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        stop_d      = stop_q | stop_i;
        if (valid_q && ready_i) valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (start_i && new_found) begin
                    scan_mask_d = ch_mask_i;
                    ch_sel_d    = new_idx;
                    cnt_d       = '0;
                    state_d     = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == SampleLast) begin
                    cnt_d   = '0;
                    mask_d  = {1'b1, {(Width-1){1'b0}}};
                    res_d   = '0;
                    state_d = ST_CONVERT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CONVERT: begin
                // Comparator only matters on the final settle cycle of each bit.
                if (cnt_q == SettleLast) begin
                    cnt_d  = '0;
                    if (cmp_i) res_d = res_q | mask_q;
                    mask_d = mask_q >> 1;
                    if (mask_q[0]) state_d = ST_STORE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STORE: begin
                if (!valid_q || ready_i) begin
                    result_d    = res_q;
                    result_ch_d = ch_sel_q;
                    valid_d     = 1'b1;
                    if (stop_q || stop_i) begin
                        state_d = ST_IDLE;
                    end else if (nxt_found) begin
                        ch_sel_d = nxt_idx;
                        state_d  = ST_SAMPLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        if (cont_i) begin
                            scan_mask_d = ch_mask_i;
                            if (new_found) begin
                                ch_sel_d = new_idx;
                                state_d  = ST_SAMPLE;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            res_q       <= '0;
            result_q    <= '0;
            ch_sel_q    <= '0;
            result_ch_q <= '0;
            scan_mask_q <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            res_q       <= res_d;
            result_q    <= result_d;
            ch_sel_q    <= ch_sel_d;
            result_ch_q <= result_ch_d;
            scan_mask_q <= scan_mask_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            stop_q      <= stop_d;
        end
    end

    assign dac_o       = res_q | mask_q;
    assign sample_o    = (state_q == ST_SAMPLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign ch_sel_o    = ch_sel_q;
    assign scan_done_o = done_q;
    assign result_o    = result_q;
    assign result_ch_o = result_ch_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_fsm_sar_scan.sv
// Directed bench: 8-bit / 4-channel instance for scan behaviour, plus a 10-bit
// single-channel instance with long settle to exercise per-bit timing.
module tb_fsm_sar_scan;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance: Width 8, 4 channels, default sample/settle.
    logic       start = 0, stop = 0, cont = 0, ready = 0;
    logic [3:0] ch_mask = '0;
    logic [7:0] dac, result;
    logic [1:0] ch_sel, result_ch;
    logic       sample, busy, scan_done, valid, cmp;
    logic [7:0] vin [4];
    assign cmp = (dac <= vin[ch_sel]);

    fsm_sar_scan #(.Width(8), .Channels(4), .SampleCycles(2), .SettleCycles(1)) dut (
        .clk_i(clk), .rst_ni(rst), .start_i(start), .stop_i(stop), .cont_i(cont),
        .ch_mask_i(ch_mask), .cmp_i(cmp), .dac_o(dac), .sample_o(sample),
        .ch_sel_o(ch_sel), .busy_o(busy), .scan_done_o(scan_done), .result_o(result),
        .result_ch_o(result_ch), .valid_o(valid), .ready_i(ready)
    );

    // Second instance: Width 10, 1 channel, SampleCycles 1, SettleCycles 3.
    logic       start6 = 0, cmp6 = 0;
    logic [0:0] mask6 = 1'b1;
    logic [9:0] dac6, result6;
    logic [0:0] ch_sel6, result_ch6;
    logic       sample6, busy6, done6, valid6;

    fsm_sar_scan #(.Width(10), .Channels(1), .SampleCycles(1), .SettleCycles(3)) dut6 (
        .clk_i(clk), .rst_ni(rst), .start_i(start6), .stop_i(1'b0), .cont_i(1'b0),
        .ch_mask_i(mask6), .cmp_i(cmp6), .dac_o(dac6), .sample_o(sample6),
        .ch_sel_o(ch_sel6), .busy_o(busy6), .scan_done_o(done6), .result_o(result6),
        .result_ch_o(result_ch6), .valid_o(valid6), .ready_i(1'b1)
    );

    int n_chk = 0, n_pass = 0;
    int bad_sel = 0;
    logic sel_mon = 0;

    always @(negedge clk)
        if (sel_mon && busy && (ch_sel == 2'd0 || ch_sel == 2'd2)) bad_sel++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Wait for the next handshake, check its payload and the scan_done flag alongside it.
    task automatic wait_result(input string tag, input logic [1:0] ch, input logic [7:0] val,
                               input logic done);
        logic seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (valid && ready) begin
                seen = 1;
                chk({tag, "_ch"}, 32'(result_ch), 32'(ch));
                chk({tag, "_val"}, 32'(result), 32'(val));
                chk({tag, "_done"}, 32'(scan_done), 32'(done));
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    initial begin
        int   lat;
        int   bad;
        logic seen;
        logic [9:0] res_m, trial;
        logic bitv;

        for (int i = 0; i < 4; i++) vin[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dac", 32'(dac), 0);
        chk("rst_sample", 32'(sample), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_done", 32'(scan_done), 0);
        rst = 1;

        // 1: single channel, latency and pass completion
        vin[0] = 8'hA5; ch_mask = 4'b0001; ready = 1;
        @(negedge clk); start = 1;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk); @(negedge clk); start = 0;
            if (valid) lat = k;
        end
        chk("t1_latency", 32'(lat), 32'd12);
        chk("t1_val", 32'(result), 32'hA5);
        chk("t1_ch", 32'(result_ch), 0);
        chk("t1_done", 32'(scan_done), 1);
        chk("t1_busy", 32'(busy), 0);
        @(negedge clk);
        chk("t1_valid_clr", 32'(valid), 0);
        chk("t1_done_clr", 32'(scan_done), 0);

        // 2: sparse mask skips disabled channels
        vin[1] = 8'h3C; vin[3] = 8'hFF; ch_mask = 4'b1010;
        sel_mon = 1;
        pulse_start();
        wait_result("t2a", 2'd1, 8'h3C, 1'b0);
        wait_result("t2b", 2'd3, 8'hFF, 1'b1);
        sel_mon = 0;
        chk("t2_badsel", 32'(bad_sel), 0);
        @(negedge clk);
        chk("t2_idle", 32'(busy), 0);

        // 3: backpressure holds first result and stalls second channel in STORE
        vin[0] = 8'h12; vin[1] = 8'h81; ch_mask = 4'b0011; ready = 0;
        pulse_start();
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        chk("t3_first_seen", 32'(seen), 1);
        chk("t3_first_val", 32'(result), 32'h12);
        chk("t3_first_ch", 32'(result_ch), 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!valid || result != 8'h12 || result_ch != 2'd0) bad++;
        end
        chk("t3_hold", 32'(bad), 0);
        chk("t3_stall_busy", 32'(busy), 1);
        chk("t3_stall_sel", 32'(ch_sel), 1);
        chk("t3_stall_dac", 32'(dac), 32'h81);
        ready = 1;
        wait_result("t3b", 2'd1, 8'h81, 1'b1);
        @(negedge clk);
        chk("t3_no_dup", 32'(valid), 0);

        // 4: continuous rescan, mask dropped mid-scan, then stop mid-convert
        vin[0] = 8'h40; vin[1] = 8'h07; cont = 1;
        pulse_start();
        wait_result("t4a", 2'd0, 8'h40, 1'b0);
        wait_result("t4b", 2'd1, 8'h07, 1'b1);
        wait_result("t4c", 2'd0, 8'h40, 1'b0);
        @(negedge clk); ch_mask = 4'b0000;
        wait_result("t4d", 2'd1, 8'h07, 1'b1);
        @(negedge clk);
        chk("t4_idle", 32'(busy), 0);

        ch_mask = 4'b0011;
        pulse_start();
        repeat (3) @(negedge clk);
        stop = 1;
        @(negedge clk); stop = 0;
        wait_result("t4e", 2'd0, 8'h40, 1'b0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample || busy || valid) bad++;
        end
        chk("t4_stopped", 32'(bad), 0);
        cont = 0;

        // 5: reset mid-convert discards pending result; start with empty mask ignored
        ready = 0;
        pulse_start();
        repeat (15) @(negedge clk);
        chk("t5_pre_busy", 32'(busy), 1);
        chk("t5_pre_valid", 32'(valid), 1);
        rst = 0;
        @(negedge clk);
        chk("t5_valid", 32'(valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_dac", 32'(dac), 0);
        chk("t5_result", 32'(result), 0);
        chk("t5_rch", 32'(result_ch), 0);
        chk("t5_sel", 32'(ch_sel), 0);
        rst = 1; ready = 1; ch_mask = 4'b0000;
        pulse_start();
        repeat (3) @(negedge clk);
        chk("t5_mask0_busy", 32'(busy), 0);
        chk("t5_mask0_sample", 32'(sample), 0);

        // 6: 3-cycle settle; comparator inverted on non-final cycles must not matter
        @(negedge clk); start6 = 1;
        @(posedge clk);
        @(negedge clk); start6 = 0;
        chk("t6_sample", 32'(sample6), 1);
        @(posedge clk);
        res_m = '0;
        for (int b = 9; b >= 0; b--) begin
            trial = res_m | (10'd1 << b);
            bitv  = (trial <= 10'h2AA);
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                cmp6 = (s == 2) ? bitv : ~bitv;
                chk($sformatf("t6_dac_b%0d_s%0d", b, s), 32'(dac6), 32'(trial));
                @(posedge clk);
            end
            if (bitv) res_m = trial;
        end
        @(posedge clk);
        @(negedge clk);
        chk("t6_valid", 32'(valid6), 1);
        chk("t6_val", 32'(result6), 32'h2AA);
        chk("t6_done", 32'(done6), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
